// File: rtl/dilithium_verify_feeder.sv
// Verify-mode front end for the dilithium core: frames one host word stream
// into sections, passes them straight through to the core and collects the verdict.
module dilithium_verify_feeder #(
  parameter int unsigned W     = 64,
  parameter int unsigned CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [2:0]       sec_lvl,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  output logic             core_start,
  output logic [2:0]       core_sec_lvl,
  output logic             core_valid_i,
  input  logic             core_ready_i,
  output logic [W-1:0]     core_data_i,
  input  logic             core_valid_o,
  output logic             core_ready_o,
  input  logic [W-1:0]     core_data_o,
  output logic             busy,
  output logic             done,
  output logic             accept,
  output logic             err,
  output logic [CYC_W-1:0] cycles
);

  localparam int unsigned WCNT_W = 32;
  localparam int unsigned MSGN_W = 30;
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  typedef enum logic [3:0] {
    IDLE, START, RHO, C, Z, T1, MLEN, MSG, H, RESULT, DONE
  } state_t;

  state_t              state, state_nx;
  logic [WCNT_W-1:0]   wcnt;
  logic [WCNT_W-1:0]   sec_len_c;
  logic [MSGN_W-1:0]   msg_words;
  logic [MSGN_W-1:0]   msg_n_c;
  logic [CYC_W-1:0]    cyc_cnt;
  logic [CYC_W-1:0]    cyc_sat_c;
  logic [31:0]         len_c;
  logic                load_c, hs_c, last_c, lvl_ok_c, res_hs_c;
  logic                unused_res_c;

  assign lvl_ok_c  = (sec_lvl == 3'b010) || (sec_lvl == 3'b011) || (sec_lvl == 3'b101);
  assign res_hs_c  = (state == RESULT) && core_valid_o && core_ready_o;
  assign cyc_sat_c = (cyc_cnt == CYC_MAX) ? CYC_MAX : cyc_cnt + CYC_W'(1);
  assign unused_res_c = ^core_data_o[W-1:1];

  // Message length in 64-bit words; a zero-length message still carries one pad word
  assign len_c   = s_data[31:0];
  assign msg_n_c = (len_c == 32'd0) ? MSGN_W'(1)
                 : MSGN_W'(len_c[31:3]) + MSGN_W'(len_c[2:0] != 3'd0);

  // Zero-latency pass-through, gated to the load states
  assign s_ready      = load_c & core_ready_i;
  assign core_valid_i = load_c & s_valid;
  assign core_data_i  = load_c ? s_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    sec_len_c = WCNT_W'(1);
    load_c    = 1'b0;
    hs_c      = 1'b0;
    last_c    = 1'b0;

    case (state)
      RHO, C: sec_len_c = WCNT_W'(4);
      Z: case (core_sec_lvl)
           3'b010:  sec_len_c = WCNT_W'(288);
           3'b011:  sec_len_c = WCNT_W'(400);
           default: sec_len_c = WCNT_W'(560);
         endcase
      T1: case (core_sec_lvl)
            3'b010:  sec_len_c = WCNT_W'(160);
            3'b011:  sec_len_c = WCNT_W'(240);
            default: sec_len_c = WCNT_W'(320);
          endcase
      MSG: sec_len_c = WCNT_W'(msg_words);
      H: sec_len_c = (core_sec_lvl == 3'b011) ? WCNT_W'(8) : WCNT_W'(11);
      default: sec_len_c = WCNT_W'(1);
    endcase

    load_c = state inside {RHO, C, Z, T1, MLEN, MSG, H};
    hs_c   = load_c & s_valid & core_ready_i;
    last_c = (wcnt == sec_len_c - WCNT_W'(1));

    case (state)
      IDLE:   if (go) state_nx = lvl_ok_c ? START : DONE;
      START:  state_nx = RHO;
      RHO:    if (hs_c && last_c) state_nx = C;
      C:      if (hs_c && last_c) state_nx = Z;
      Z:      if (hs_c && last_c) state_nx = T1;
      T1:     if (hs_c && last_c) state_nx = MLEN;
      MLEN:   if (hs_c && last_c) state_nx = MSG;
      MSG:    if (hs_c && last_c) state_nx = H;
      H:      if (hs_c && last_c) state_nx = RESULT;
      RESULT: if (res_hs_c) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered control outputs, section counters and job results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt         <= '0;
      msg_words    <= '0;
      cyc_cnt      <= '0;
      core_start   <= 1'b0;
      core_sec_lvl <= 3'b000;
      core_ready_o <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      accept       <= 1'b0;
      err          <= 1'b0;
      cycles       <= '0;
    end else begin
      core_start   <= (state_nx == START);
      core_ready_o <= (state_nx == RESULT);
      busy         <= (state_nx != IDLE);
      done         <= (state_nx == DONE);

      if (hs_c)         wcnt <= last_c ? '0 : wcnt + WCNT_W'(1);
      else if (!load_c) wcnt <= '0;

      if (hs_c && (state == MLEN)) msg_words <= msg_n_c;

      if ((state == IDLE) && go) begin
        accept  <= 1'b0;
        err     <= !lvl_ok_c;
        cycles  <= '0;
        cyc_cnt <= '0;
        if (lvl_ok_c) core_sec_lvl <= sec_lvl;
      end else if ((state != IDLE) && (state != DONE)) begin
        cyc_cnt <= cyc_sat_c;
      end

      // Bit 0 of the core result word set means the signature was rejected
      if (res_hs_c) begin
        accept <= ~core_data_o[0];
        cycles <= cyc_sat_c;
      end
    end
  end

endmodule

// File: tb/tb_dilithium_verify_feeder.sv
// Directed bench for dilithium_verify_feeder: scoreboarded word forwarding,
// section counts, result handling, invalid level and mid-job reset.
module tb_dilithium_verify_feeder;
  localparam int unsigned W     = 64;
  localparam int unsigned CYC_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic [2:0]       sec_lvl;
  logic             s_valid;
  logic             s_ready;
  logic [W-1:0]     s_data;
  logic             core_start;
  logic [2:0]       core_sec_lvl;
  logic             core_valid_i;
  logic             core_ready_i;
  logic [W-1:0]     core_data_i;
  logic             core_valid_o;
  logic             core_ready_o;
  logic [W-1:0]     core_data_o;
  logic             busy;
  logic             done;
  logic             accept;
  logic             err;
  logic [CYC_W-1:0] cycles;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb[$];

  always #5 clk = ~clk;

  dilithium_verify_feeder #(.W(W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .go(go), .sec_lvl(sec_lvl),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .core_start(core_start), .core_sec_lvl(core_sec_lvl),
    .core_valid_i(core_valid_i), .core_ready_i(core_ready_i), .core_data_i(core_data_i),
    .core_valid_o(core_valid_o), .core_ready_o(core_ready_o), .core_data_o(core_data_o),
    .busy(busy), .done(done), .accept(accept), .err(err), .cycles(cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one complete valid job; returns the load cycles spent on the host side
  task automatic run_job(input logic [2:0] lvl, input logic [31:0] len, input logic res,
                         input bit bp, input bit go_busy, output int load_cyc);
    logic [63:0] words[$];
    logic [63:0] exp;
    int cnt[7];
    int zc, tc, hc, n, idx, guard, starts, early_rdy, early_done, hs_cnt, res_cyc;
    bit sv, cr, got;

    zc = (lvl == 3'b010) ? 288 : (lvl == 3'b011) ? 400 : 560;
    tc = (lvl == 3'b010) ? 160 : (lvl == 3'b011) ? 240 : 320;
    hc = (lvl == 3'b011) ? 8 : 11;
    n  = (len == 32'd0) ? 1 : int'((longint'(len) + 64'd7) / 64'd8);
    cnt = '{4, 4, zc, tc, 1, n, hc};
    for (int s = 0; s < 7; s++)
      for (int i = 0; i < cnt[s]; i++)
        if (s == 4) words.push_back({32'($urandom), len});
        else        words.push_back({4'(s), 28'(i), 32'($urandom)});

    @(negedge clk);
    go = 1'b1; sec_lvl = lvl; s_valid = 1'b0; core_ready_i = 1'b1;
    core_valid_o = 1'b1;
    core_data_o = {32'($urandom), 31'($urandom), res};
    @(negedge clk);
    #1;
    chk("start_pulse", 64'(core_start), 64'd1);
    chk("start_lvl", 64'(core_sec_lvl), 64'(lvl));
    go = go_busy;

    idx = 0; guard = 0; starts = 0; early_rdy = 0; early_done = 0; hs_cnt = 0;
    load_cyc = 0;
    while (idx < words.size() && guard < 20000) begin
      @(negedge clk);
      sv = bp ? ($urandom_range(3) != 0) : 1'b1;
      cr = bp ? 1'($urandom_range(1)) : 1'b1;
      s_valid = sv; core_ready_i = cr;
      s_data = sv ? words[idx] : {$urandom, $urandom};
      #1;
      if (core_start) starts++;
      if (core_ready_o) early_rdy++;
      if (done) early_done++;
      if (core_valid_i && core_ready_i) hs_cnt++;
      chk("pass_through", {62'd0, s_ready, core_valid_i}, {62'd0, cr, sv});
      if (sv && cr) begin
        sb.push_back(words[idx]);
        exp = sb.pop_front();
        chk("fwd_data", core_data_i, exp);
        idx++;
      end
      load_cyc++; guard++;
    end
    chk("load_complete", 64'(idx), 64'(words.size()));

    go = 1'b0; res_cyc = 0; got = 1'b0; guard = 0;
    while (!got && guard < 100) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = {$urandom, $urandom}; core_ready_i = 1'b1;
      #1;
      chk("no_extra_word", {62'd0, s_ready, core_valid_i}, 64'd0);
      res_cyc++; guard++;
      if (core_ready_o) got = 1'b1;
    end
    chk("result_ack", 64'(got), 64'd1);

    @(negedge clk);
    s_valid = 1'b0; core_valid_o = 1'b0;
    #1;
    chk("done_pulse", {60'd0, done, busy, accept, err}, {60'd0, 1'b1, 1'b1, ~res, 1'b0});
    chk("cycles", 64'(cycles), 64'(1 + load_cyc + res_cyc));
    chk("core_handshakes", 64'(hs_cnt), 64'(words.size()));
    chk("single_start_no_early", 64'({starts, early_rdy, early_done} != 0), 64'd0);
    @(negedge clk);
    #1;
    chk("after_done", {61'd0, done, busy, accept}, {61'd0, 1'b0, 1'b0, ~res});
  endtask

  initial begin
    int lc;
    logic [31:0] lens[4];
    rst = 1'b1; go = 1'b0; sec_lvl = 3'b000; s_valid = 1'b1;
    s_data = 64'hdead_beef_cafe_f00d; core_ready_i = 1'b1;
    core_valid_o = 1'b0; core_data_o = '0;
    #1;
    chk("reset_ctrl", {56'd0, s_ready, core_valid_i, core_start, busy, done, accept, err, core_ready_o}, 64'd0);
    chk("reset_data", core_data_i, 64'd0);
    chk("reset_lvl_cyc", {29'd0, core_sec_lvl, cycles}, 64'd0);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // level 2, L=33, back-to-back, accepted
    run_job(3'b010, 32'd33, 1'b0, 1'b0, 1'b0, lc);
    chk("l2_load_cycles", 64'(lc), 64'd473);
    chk("l2_cycles", 64'(cycles), 64'd475);

    // level 5 reject, go held high while busy
    run_job(3'b101, 32'd100, 1'b1, 1'b0, 1'b1, lc);
    chk("l5_load_cycles", 64'(lc), 64'd4 + 4 + 560 + 320 + 1 + 13 + 11);

    // backpressure on both sides, level 3, L=8
    run_job(3'b011, 32'd8, 1'b0, 1'b1, 1'b0, lc);

    // message length boundaries
    lens = '{32'd0, 32'd1, 32'd8, 32'd9};
    foreach (lens[k]) run_job(3'b010, lens[k], 1'b0, 1'b0, 1'b0, lc);

    // invalid level
    @(negedge clk);
    go = 1'b1; sec_lvl = 3'b100; s_valid = 1'b1; core_ready_i = 1'b1;
    @(negedge clk);
    go = 1'b0;
    #1;
    chk("inv_done", {59'd0, done, err, busy, accept, core_start}, {59'd0, 5'b11100});
    chk("inv_sready", 64'(s_ready), 64'd0);
    chk("inv_cycles", 64'(cycles), 64'd0);
    @(negedge clk);
    #1;
    chk("inv_after", {60'd0, done, err, busy, s_ready}, {60'd0, 4'b0100});
    s_valid = 1'b0;

    // reset pulsed while Z is loading
    @(negedge clk);
    go = 1'b1; sec_lvl = 3'b010;
    @(negedge clk);
    go = 1'b0;
    repeat (30) begin
      @(negedge clk);
      s_valid = 1'b1; core_ready_i = 1'b1; s_data = {$urandom, $urandom} | 64'd1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {56'd0, s_ready, core_valid_i, core_start, busy, done, accept, err, core_ready_o}, 64'd0);
    chk("midrst_data", core_data_i, 64'd0);
    chk("midrst_lvl_cyc", {29'd0, core_sec_lvl, cycles}, 64'd0);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    run_job(3'b010, 32'd16, 1'b0, 1'b0, 1'b0, lc);
    chk("post_rst_load", 64'(lc), 64'd4 + 4 + 288 + 160 + 1 + 2 + 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
